// File: rtl/down_timer.sv
// -----------------------------------------------------------------------------
// down_timer
//   Loadable, pausable down-counting timer. Counts from a programmed value to 0
//   and pulses tc while showing 0 in RUN. At 0 it then either stops in DONE or
//   auto-reloads and keeps running. Typical uses are a one-shot delay or a
//   periodic tick. With auto_reload and a load value of 2**WIDTH-1, tc repeats
//   every 2**WIDTH cycles.
//
// Ports
//   clk          in   1      single clock, all state updates on posedge
//   reset        in   1      synchronous, active-high reset
//   load         in   1      capture load_val into count and reload register,
//                            abort to IDLE
//   load_val     in   WIDTH  value to load
//   start        in   1      begin counting (accepted in IDLE or DONE only)
//   pause        in   1      level: hold count while high (RUN <-> PAUSED)
//   auto_reload  in   1      level: on reaching 0, reload instead of stopping
//   count        out  WIDTH  current count (registered)
//   tc           out  1      terminal count (registered)
//   busy         out  1      high in RUN or PAUSED
//   done         out  1      high in DONE
// -----------------------------------------------------------------------------
module down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] reload_reg;

  // Next-state and next-count decode. Priority below reset is
  // load > start > pause > counting. Start is only honoured in IDLE or DONE;
  // in RUN/PAUSED it falls through to the normal run/pause handling. The
  // count never wraps: reaching 0 is resolved by either reloading or
  // stopping in DONE.
  always_comb begin
    next_state = state;
    next_count = count;
    if (load) begin
      next_state = IDLE;
      next_count = load_val;
    end else if (start && (state == IDLE || state == DONE)) begin
      next_state = RUN;
      if (state == DONE) begin
        next_count = reload_reg;
      end
    end else begin
      case (state)
        RUN: begin
          if (pause) begin
            next_state = PAUSED;
          end else if (count != '0) begin
            next_count = count - 1'b1;
          end else if (auto_reload) begin
            next_count = reload_reg;
          end else begin
            next_state = DONE;
          end
        end
        PAUSED: begin
          if (!pause) begin
            next_state = RUN;
          end
        end
        default: begin
          next_state = state;
        end
      endcase
    end
  end

  // State, count, reload register and tc. tc is computed from the values
  // being registered, so it is high exactly in the cycles where RUN shows 0.
  // That single rule also covers the zero-load and paused-at-zero cases.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
    end else begin
      state <= next_state;
      count <= next_count;
      tc    <= (next_state == RUN) && (next_count == '0);
      if (load) begin
        reload_reg <= load_val;
      end
    end
  end

  assign busy = (state == RUN) || (state == PAUSED);
  assign done = (state == DONE);

endmodule

// File: tb/tb_down_timer.sv
// -----------------------------------------------------------------------------
// tb_down_timer
//   Directed scoreboard bench for down_timer (WIDTH=4). Each stimulus step
//   drives the inputs for one clock edge and queues the outputs expected
//   after that edge. A separate monitor pops one entry per edge and compares.
// -----------------------------------------------------------------------------
module tb_down_timer;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;
    string            name;
  } exp_t;

  exp_t expq[$];
  int   compared   = 0;
  int   mismatched = 0;

  down_timer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .pause       (pause),
    .auto_reload (auto_reload),
    .count       (count),
    .tc          (tc),
    .busy        (busy),
    .done        (done)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one edge worth of inputs on the falling edge and queue the
  // outputs expected right after the following rising edge.
  task automatic applyStimulus(
    input logic             r,
    input logic             l,
    input logic [WIDTH-1:0] lv,
    input logic             s,
    input logic             p,
    input logic             ar,
    input logic [WIDTH-1:0] ec,
    input logic             et,
    input logic             eb,
    input logic             ed,
    input string            nm
  );
    exp_t e;
    @(negedge clk);
    reset       = r;
    load        = l;
    load_val    = lv;
    start       = s;
    pause       = p;
    auto_reload = ar;
    e.count = ec;
    e.tc    = et;
    e.busy  = eb;
    e.done  = ed;
    e.name  = nm;
    expq.push_back(e);
  endtask

  // Compare the DUT outputs against one scoreboard entry.
  task automatic checkOutput(input exp_t e);
    compared++;
    if (count !== e.count || tc !== e.tc || busy !== e.busy || done !== e.done) begin
      mismatched++;
      $display("[TB] FAIL %s: got count=%0d tc=%b busy=%b done=%b, expected count=%0d tc=%b busy=%b done=%b",
               e.name, count, tc, busy, done, e.count, e.tc, e.busy, e.done);
    end
  endtask

  // Monitor: shortly after each rising edge, check the entry queued for it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput(e);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected run to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] c;
    reset = 1'b1; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0; auto_reload = 1'b0;

    // Reset state
    applyStimulus(1,0,0,0,0,0, 0,0,0,0, "reset0");
    applyStimulus(1,0,0,1,0,0, 0,0,0,0, "reset1");

    // 1: reset mid-run
    applyStimulus(0,1,9,0,0,0, 9,0,0,0, "t1_load9");
    applyStimulus(0,0,0,1,0,0, 9,0,1,0, "t1_start");
    applyStimulus(0,0,0,0,0,0, 8,0,1,0, "t1_run8");
    applyStimulus(0,0,0,0,0,0, 7,0,1,0, "t1_run7");
    applyStimulus(0,0,0,0,0,0, 6,0,1,0, "t1_run6");
    applyStimulus(1,0,0,1,0,0, 0,0,0,0, "t1_reset");
    applyStimulus(0,0,0,0,0,0, 0,0,0,0, "t1_idle");

    // 2: one-shot from 3
    applyStimulus(0,1,3,0,0,0, 3,0,0,0, "t2_load3");
    applyStimulus(0,0,0,1,0,0, 3,0,1,0, "t2_start");
    applyStimulus(0,0,0,0,0,0, 2,0,1,0, "t2_run2");
    applyStimulus(0,0,0,0,0,0, 1,0,1,0, "t2_run1");
    applyStimulus(0,0,0,0,0,0, 0,1,1,0, "t2_tc");
    for (int i = 0; i < 10; i++)
      applyStimulus(0,0,0,0,0,0, 0,0,0,1, "t2_done_hold");

    // 3: auto-reload from 15, tc once every 16 cycles
    applyStimulus(0,1,15,0,0,1, 15,0,0,0, "t3_load15");
    applyStimulus(0,0,0,1,0,1, 15,0,1,0, "t3_start");
    for (int i = 1; i <= 64; i++) begin
      c = WIDTH'(15 - (i % 16));
      applyStimulus(0,0,0,0,0,1, c, (c == 0), 1, 0, "t3_autoreload");
    end
    applyStimulus(0,1,0,0,0,0, 0,0,0,0, "t3_abort");

    // 4: pause at 3 for 4 cycles
    applyStimulus(0,1,5,0,0,0, 5,0,0,0, "t4_load5");
    applyStimulus(0,0,0,1,0,0, 5,0,1,0, "t4_start");
    applyStimulus(0,0,0,0,0,0, 4,0,1,0, "t4_run4");
    applyStimulus(0,0,0,0,0,0, 3,0,1,0, "t4_run3");
    for (int i = 0; i < 4; i++)
      applyStimulus(0,0,0,0,1,0, 3,0,1,0, "t4_paused");
    applyStimulus(0,0,0,0,0,0, 3,0,1,0, "t4_resume");
    applyStimulus(0,0,0,0,0,0, 2,0,1,0, "t4_run2");
    applyStimulus(0,0,0,0,0,0, 1,0,1,0, "t4_run1");
    applyStimulus(0,0,0,0,0,0, 0,1,1,0, "t4_tc");
    applyStimulus(0,0,0,0,0,0, 0,0,0,1, "t4_done");

    // 5: abort with load+start in RUN, start ignored while running, restart from DONE
    applyStimulus(0,1,9,0,0,0, 9,0,0,0, "t5_load9");
    applyStimulus(0,0,0,1,0,0, 9,0,1,0, "t5_start");
    applyStimulus(0,0,0,0,0,0, 8,0,1,0, "t5_run8");
    applyStimulus(0,0,0,0,0,0, 7,0,1,0, "t5_run7");
    applyStimulus(0,0,0,0,0,0, 6,0,1,0, "t5_run6");
    applyStimulus(0,0,0,0,0,0, 5,0,1,0, "t5_run5");
    applyStimulus(0,0,0,0,0,0, 4,0,1,0, "t5_run4");
    applyStimulus(0,1,7,1,0,0, 7,0,0,0, "t5_load_start");
    applyStimulus(0,0,0,1,0,0, 7,0,1,0, "t5_start7");
    applyStimulus(0,0,0,1,0,0, 6,0,1,0, "t5_start_ignored");
    for (int i = 5; i >= 1; i--)
      applyStimulus(0,0,0,0,0,0, WIDTH'(i),0,1,0, "t5_run");
    applyStimulus(0,0,0,0,0,0, 0,1,1,0, "t5_tc");
    applyStimulus(0,0,0,0,0,0, 0,0,0,1, "t5_done");
    applyStimulus(0,0,0,1,0,0, 7,0,1,0, "t5_restart_reload");
    applyStimulus(0,0,0,0,0,0, 6,0,1,0, "t5_restart_run6");

    // 6: zero cases
    applyStimulus(0,1,0,0,0,0, 0,0,0,0, "t6_load0");
    applyStimulus(0,0,0,1,0,0, 0,1,1,0, "t6_start0_tc");
    applyStimulus(0,0,0,0,0,0, 0,0,0,1, "t6_done");
    applyStimulus(0,0,0,1,0,0, 0,1,1,0, "t6_restart0_tc");
    applyStimulus(0,0,0,0,0,0, 0,0,0,1, "t6_done2");
    applyStimulus(0,1,0,0,0,1, 0,0,0,0, "t6_load0_ar");
    applyStimulus(0,0,0,1,0,1, 0,1,1,0, "t6_ar_start");
    for (int i = 0; i < 4; i++)
      applyStimulus(0,0,0,0,0,1, 0,1,1,0, "t6_ar_tc_held");
    applyStimulus(0,0,0,0,1,1, 0,0,1,0, "t6_paused_at0");
    applyStimulus(0,0,0,0,1,1, 0,0,1,0, "t6_paused_at0b");
    applyStimulus(0,0,0,0,0,1, 0,1,1,0, "t6_resume_at0");
    applyStimulus(0,0,0,0,0,0, 0,0,0,1, "t6_ar_off_done");
    applyStimulus(1,0,0,0,0,0, 0,0,0,0, "t6_reset_from_done");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
    #2;
    if (expq.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
